// File: rtl/msgpass_buffer_mp.sv
// Multi-port message-passing buffer: zero-init sequencer, lowest-port-wins write arbitration,
// conflict statistics and a fixed-latency read pipeline. Write-first forwarding under MSGPASS_BUFF_BYPASS_EN.
module msgpass_buffer_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             ren_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  input  logic [NUM_PORTS-1:0]             wen_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic                             init_done_o,
  output logic                             conflict_o,
  output logic [15:0]                      conflict_cnt_o,
  input  logic                             clr_cnt_i
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           init_addr_q, init_addr_d;
  logic [DATA_WIDTH-1:0]           mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]           raddr_s [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]           waddr_s [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           wdata_s [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           rd_word_s [NUM_PORTS];
  logic                            ready_s;
  logic [NUM_PORTS-1:0]            shadowed_s;
  logic [NUM_PORTS-1:0]            we_win_s;
  logic                            conflict_s;
  logic                            conflict_q;
  logic [15:0]                     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]            rd_vld_s;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rd_dat_s;
  logic [NUM_PORTS-1:0]            vld_q [RD_LATENCY];
  logic [NUM_PORTS*DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (32'(addr) < 32'(DEPTH));
  endfunction

  assign ready_s = (state_q == ST_READY) && !rst_i;

  // Unpack the flat port buses into per-port arrays
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      raddr_s[p] = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      waddr_s[p] = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_s[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM state and init address register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // FSM next state: sweep every address once, then stay READY until reset
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        if (init_addr_q == ADDR_LAST) begin
          state_d     = ST_READY;
          init_addr_d = '0;
        end else begin
          state_d     = ST_INIT;
          init_addr_d = init_addr_q + ADDR_ONE;
        end
      end
      ST_READY: begin
        state_d     = ST_READY;
        init_addr_d = '0;
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
      end
    endcase
  end

  // A write port is shadowed when any lower-indexed enabled port targets the same address
  always_comb begin
    shadowed_s = '0;
    we_win_s   = '0;
    conflict_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        shadowed_s[p] = shadowed_s[p] |
                        ((q < p) && wen_i[q] && wen_i[p] && (waddr_s[q] == waddr_s[p]));
      end
      we_win_s[p] = ready_s && wen_i[p] && !shadowed_s[p] && addr_in_range(waddr_s[p]);
      conflict_s  = conflict_s | (ready_s && shadowed_s[p]);
    end
  end

  // Storage: zero fill during INIT, arbitrated port writes once READY
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[init_addr_q] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (we_win_s[p]) begin
          mem_q[waddr_s[p]] <= wdata_s[p];
        end
      end
    end
  end

  // Read sample stage; invalid lanes carry zero data down the pipe
  always_comb begin
    rd_vld_s = '0;
    rd_dat_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_vld_s[p] = ready_s && ren_i[p];
      if (rd_vld_s[p] && addr_in_range(raddr_s[p])) begin
        rd_word_s[p] = mem_q[raddr_s[p]];
      end else begin
        rd_word_s[p] = '0;
      end
`ifdef MSGPASS_BUFF_BYPASS_EN
      // At most one winning write per address, so scan order does not matter
      for (int q = 0; q < NUM_PORTS; q++) begin
        rd_word_s[p] = (rd_vld_s[p] && we_win_s[q] && (waddr_s[q] == raddr_s[p])) ?
                       wdata_s[q] : rd_word_s[p];
      end
`endif
      rd_dat_s[p*DATA_WIDTH +: DATA_WIDTH] = rd_word_s[p];
    end
  end

  // Read pipeline, flushed by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        vld_q[s] <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= rd_vld_s;
      dat_q[0] <= rd_dat_s;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  // Conflict counter next value: clear beats increment, saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = 16'h0000;
    end else if (conflict_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Conflict flag and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      conflict_q <= conflict_s;
      cnt_q      <= cnt_d;
    end
  end

  assign rvalid_o       = vld_q[RD_LATENCY-1];
  assign rdata_o        = dat_q[RD_LATENCY-1];
  assign init_done_o    = (state_q == ST_READY);
  assign conflict_o     = conflict_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_msgpass_buffer_mp.sv
// Directed self-checking bench for msgpass_buffer_mp (DEPTH=64, two ports, RD_LATENCY=2).
module tb_msgpass_buffer_mp;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NP    = 2;
  localparam int RL    = 2;

`ifdef MSGPASS_BUFF_BYPASS_EN
  localparam logic [15:0] EXP_RDW = 16'h00FF;
`else
  localparam logic [15:0] EXP_RDW = 16'h0F0F;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    ren;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata;
  logic [NP-1:0]    rvalid;
  logic [NP-1:0]    wen;
  logic [NP*AW-1:0] waddr;
  logic [NP*DW-1:0] wdata;
  logic             init_done;
  logic             conflict;
  logic [15:0]      cnt;
  logic             clr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msgpass_buffer_mp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .RD_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
    .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
    .init_done_o(init_done), .conflict_o(conflict), .conflict_cnt_o(cnt),
    .clr_cnt_i(clr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren   = '0;
    wen   = '0;
    raddr = '0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p]             = 1'b1;
    waddr[p*AW +: AW]  = a;
    wdata[p*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    ren[p]            = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  initial begin
    rst     = 1'b1;
    clr_cnt = 1'b0;
    idle();
    repeat (3) tick();
    check_eq("rst_rvalid", 32'(rvalid), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_init_done", 32'(init_done), 32'h0);
    check_eq("rst_conflict", 32'(conflict), 32'h0);
    check_eq("rst_cnt", 32'(cnt), 32'h0);

    // INIT sweep with reads requested: nothing valid, done after exactly 64 edges
    rst = 1'b0;
    set_rd(0, 6'd3);
    set_rd(1, 6'd9);
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 61) idle();
      tick();
      check_eq("init_rvalid", 32'(rvalid), 32'h0);
      check_eq("init_done_edge", 32'(init_done), (k == DEPTH) ? 32'h1 : 32'h0);
    end

    // Every address reads back zero after RL cycles
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        set_rd(0, AW'(i));
        set_rd(1, AW'(DEPTH - 1 - i));
      end else begin
        idle();
      end
      tick();
      if (i == 0) begin
        check_eq("zero_rd_early", 32'(rvalid), 32'h0);
      end else begin
        check_eq("zero_rd_valid", 32'(rvalid), 32'h3);
        check_eq("zero_rd_data", 32'(rdata), 32'h0);
      end
    end
    tick();
    check_eq("zero_rd_drain", 32'(rvalid), 32'h0);

    // Write then read next cycle, latency 2, single-cycle valid
    set_wr(0, 6'd3, 16'hA5A5);
    tick();
    idle();
    set_rd(1, 6'd3);
    tick();
    idle();
    check_eq("lat_not_yet", 32'(rvalid), 32'h0);
    tick();
    check_eq("lat_valid", 32'(rvalid), 32'h2);
    check_eq("lat_data", 32'(rd(1)), 32'hA5A5);
    tick();
    check_eq("lat_valid_drop", 32'(rvalid), 32'h0);
    check_eq("lat_data_zero", 32'(rd(1)), 32'h0);

    // Same-address conflict: port 0 wins
    set_wr(0, 6'd7, 16'h1111);
    set_wr(1, 6'd7, 16'h2222);
    tick();
    idle();
    check_eq("cfl_pulse", 32'(conflict), 32'h1);
    check_eq("cfl_cnt", 32'(cnt), 32'h1);
    tick();
    check_eq("cfl_pulse_end", 32'(conflict), 32'h0);
    check_eq("cfl_cnt_hold", 32'(cnt), 32'h1);
    set_rd(0, 6'd7);
    tick();
    idle();
    tick();
    check_eq("cfl_winner", 32'(rd(0)), 32'h1111);

    // Distinct-address dual write, cross reads, then both ports on one address
    set_wr(0, 6'd10, 16'h1234);
    set_wr(1, 6'd11, 16'h5678);
    tick();
    idle();
    check_eq("dual_no_cfl", 32'(conflict), 32'h0);
    set_rd(0, 6'd11);
    set_rd(1, 6'd10);
    tick();
    idle();
    tick();
    check_eq("dual_rd0", 32'(rd(0)), 32'h5678);
    check_eq("dual_rd1", 32'(rd(1)), 32'h1234);
    set_rd(0, 6'd10);
    set_rd(1, 6'd10);
    tick();
    idle();
    tick();
    check_eq("same_rd", 32'(rdata), 32'h12341234);

    // Read during write to the same address
    set_wr(0, 6'd5, 16'h0F0F);
    tick();
    idle();
    set_wr(0, 6'd5, 16'h00FF);
    set_rd(1, 6'd5);
    tick();
    idle();
    tick();
    check_eq("rdw_data", 32'(rd(1)), 32'(EXP_RDW));
    set_rd(0, 6'd5);
    tick();
    idle();
    tick();
    check_eq("rdw_after", 32'(rd(0)), 32'h00FF);

    // Saturation: counter is 1, run it up to FFFE then past the top
    set_wr(0, 6'd0, 16'h0001);
    set_wr(1, 6'd0, 16'h0002);
    repeat (65533) tick();
    check_eq("sat_fffe", 32'(cnt), 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("sat_hold", 32'(cnt), 32'hFFFF);
      check_eq("sat_cfl", 32'(conflict), 32'h1);
    end
    clr_cnt = 1'b1;
    tick();
    check_eq("clr_wins", 32'(cnt), 32'h0);
    check_eq("clr_cfl", 32'(conflict), 32'h1);
    clr_cnt = 1'b0;
    idle();
    tick();
    check_eq("clr_stay", 32'(cnt), 32'h0);
    check_eq("clr_cfl_end", 32'(conflict), 32'h0);

    // Mid-operation reset clears counter; reset again at INIT address 30
    set_wr(0, 6'd40, 16'hBEEF);
    set_wr(1, 6'd40, 16'h0000);
    tick();
    idle();
    check_eq("pre_rst_cnt", 32'(cnt), 32'h1);
    rst = 1'b1;
    tick();
    check_eq("rst2_cnt", 32'(cnt), 32'h0);
    check_eq("rst2_done", 32'(init_done), 32'h0);
    rst = 1'b0;
    repeat (30) tick();
    check_eq("mid_init_done", 32'(init_done), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DEPTH - 1) tick();
    check_eq("reinit_not_done", 32'(init_done), 32'h0);
    tick();
    check_eq("reinit_done", 32'(init_done), 32'h1);
    set_rd(0, 6'd40);
    set_rd(1, 6'd30);
    tick();
    idle();
    tick();
    check_eq("reinit_valid", 32'(rvalid), 32'h3);
    check_eq("reinit_zero", 32'(rdata), 32'h0);

    // Reset with reads in flight: no valid pulses afterwards
    set_rd(0, 6'd1);
    set_rd(1, 6'd2);
    tick();
    rst = 1'b1;
    tick();
    check_eq("flush_valid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 11) idle();
      tick();
      check_eq("flush_quiet", 32'(rvalid), 32'h0);
    end
    check_eq("flush_done", 32'(init_done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
